// File: rtl/fifo_pkg.sv
// Shared widths and defaults for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 10;

  // Pointer width never drops below one bit, even for tiny depths.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Slot pointer with enable that wraps from DEPTH-1 back to 0; depth need not be a power of 2.
module fifo_ptr_wrap #(
  parameter int DEPTH = 10,
  parameter int PTR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with level, watermark flags, sticky error flags and a read strobe.
// Define FIFO_WATERMARK_EN to add the peak_level / peak_clear high-water tracker.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = DEFAULT_DATA_W,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int AF_THRESH = 8,
  parameter  int AE_THRESH = 2,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_irq,
  input  logic              tx_irq,
  input  logic              err_clear,
`ifdef FIFO_WATERMARK_EN
  input  logic              peak_clear,
  output logic [CNT_W-1:0]  peak_level,
`endif
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic [PTR_W-1:0]  write_pointer,
  output logic [PTR_W-1:0]  read_pointer,
  output logic [CNT_W-1:0]  level,
  output logic              Empty_Flag,
  output logic              Full_Flag,
  output logic              Almost_Full,
  output logic              Almost_Empty,
  output logic              Overflow,
  output logic              Underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;
  logic [CNT_W-1:0]  level_next;

  assign Empty_Flag   = (level == '0);
  assign Full_Flag    = (level == CNT_W'(DEPTH));
  assign Almost_Full  = (level >= CNT_W'(AF_THRESH));
  assign Almost_Empty = (level <= CNT_W'(AE_THRESH));

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_ok = tx_irq & ~Empty_Flag;
  assign wr_ok = rx_irq & (~Full_Flag | rd_ok);

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .en    (wr_ok),
    .ptr   (write_pointer)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .en    (rd_ok),
    .ptr   (read_pointer)
  );

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[write_pointer] <= rx_data;
    end
  end

  always_comb begin
    level_next = level;
    if (wr_ok && !rd_ok) begin
      level_next = level + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      level_next = level - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      level    <= level_next;
      tx_valid <= rd_ok;
      if (rd_ok) begin
        tx_data <= mem[read_pointer];
      end
    end
  end

  // A fresh error outranks err_clear arriving in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (rx_irq && !wr_ok) begin
        Overflow <= 1'b1;
      end else if (err_clear) begin
        Overflow <= 1'b0;
      end
      if (tx_irq && !rd_ok) begin
        Underflow <= 1'b1;
      end else if (err_clear) begin
        Underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_WATERMARK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_level <= '0;
    end else if (peak_clear || (level_next > peak_level)) begin
      peak_level <= level_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised self-checking bench for fifo_sync_param against a queue-based reference model.
// Exercises the FIFO_WATERMARK_EN tracker too when that macro is defined.
module tb_fifo_sync_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 10;
  localparam int AF     = 8;
  localparam int AE     = 2;
  localparam int PTR_W  = 4;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] rx_data;
  logic              rx_irq;
  logic              tx_irq;
  logic              err_clear;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [PTR_W-1:0]  write_pointer;
  logic [PTR_W-1:0]  read_pointer;
  logic [CNT_W-1:0]  level;
  logic              Empty_Flag;
  logic              Full_Flag;
  logic              Almost_Full;
  logic              Almost_Empty;
  logic              Overflow;
  logic              Underflow;
`ifdef FIFO_WATERMARK_EN
  logic              peak_clear;
  logic [CNT_W-1:0]  peak_level;
  int                mPeak;
`endif

  logic [DATA_W-1:0] mQueue[$];
  logic [DATA_W-1:0] mTxData;
  logic              mTxValid;
  logic              mOverflow;
  logic              mUnderflow;
  int                mWrPtr;
  int                mRdPtr;
  int                numChecks;
  int                numFails;

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_irq        (rx_irq),
    .tx_irq        (tx_irq),
    .err_clear     (err_clear),
`ifdef FIFO_WATERMARK_EN
    .peak_clear    (peak_clear),
    .peak_level    (peak_level),
`endif
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .write_pointer (write_pointer),
    .read_pointer  (read_pointer),
    .level         (level),
    .Empty_Flag    (Empty_Flag),
    .Full_Flag     (Full_Flag),
    .Almost_Full   (Almost_Full),
    .Almost_Empty  (Almost_Empty),
    .Overflow      (Overflow),
    .Underflow     (Underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    int lvl;
    lvl = mQueue.size();
    checkOutput("level", 32'(level), 32'(lvl));
    checkOutput("Empty_Flag", 32'(Empty_Flag), 32'(lvl == 0));
    checkOutput("Full_Flag", 32'(Full_Flag), 32'(lvl == DEPTH));
    checkOutput("Almost_Full", 32'(Almost_Full), 32'(lvl >= AF));
    checkOutput("Almost_Empty", 32'(Almost_Empty), 32'(lvl <= AE));
    checkOutput("Overflow", 32'(Overflow), 32'(mOverflow));
    checkOutput("Underflow", 32'(Underflow), 32'(mUnderflow));
    checkOutput("tx_valid", 32'(tx_valid), 32'(mTxValid));
    checkOutput("tx_data", 32'(tx_data), 32'(mTxData));
    checkOutput("write_pointer", 32'(write_pointer), 32'(mWrPtr));
    checkOutput("read_pointer", 32'(read_pointer), 32'(mRdPtr));
`ifdef FIFO_WATERMARK_EN
    checkOutput("peak_level", 32'(peak_level), 32'(mPeak));
`endif
  endtask

  task automatic modelReset();
    mQueue.delete();
    mTxData    = '0;
    mTxValid   = 1'b0;
    mOverflow  = 1'b0;
    mUnderflow = 1'b0;
    mWrPtr     = 0;
    mRdPtr     = 0;
`ifdef FIFO_WATERMARK_EN
    mPeak      = 0;
`endif
  endtask

  // Drive one cycle of requests, advance the model, then check just after the edge.
  task automatic applyStimulus(input logic rx, input logic [DATA_W-1:0] d, input logic tx, input logic clr);
    logic rdOk;
    logic wrOk;
    rx_irq    = rx;
    rx_data   = d;
    tx_irq    = tx;
    err_clear = clr;
    rdOk = tx && (mQueue.size() > 0);
    wrOk = rx && ((mQueue.size() < DEPTH) || rdOk);
    mTxValid = rdOk;
    if (rdOk) begin
      mTxData = mQueue.pop_front();
      mRdPtr  = (mRdPtr + 1) % DEPTH;
    end
    if (wrOk) begin
      mQueue.push_back(d);
      mWrPtr = (mWrPtr + 1) % DEPTH;
    end
    if (rx && !wrOk) mOverflow = 1'b1;
    else if (clr) mOverflow = 1'b0;
    if (tx && !rdOk) mUnderflow = 1'b1;
    else if (clr) mUnderflow = 1'b0;
`ifdef FIFO_WATERMARK_EN
    if (peak_clear || (mQueue.size() > mPeak)) mPeak = mQueue.size();
`endif
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic idleInputs();
    rx_irq    = 1'b0;
    tx_irq    = 1'b0;
    err_clear = 1'b0;
    rx_data   = '0;
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    reset = 1'b1;
`ifdef FIFO_WATERMARK_EN
    peak_clear = 1'b0;
`endif
    idleInputs();
    modelReset();
    #2 reset = 1'b0;
    #2;
    checkAll();
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] fill to full, then overflow");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] drain to empty, then underflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] simultaneous read and write while full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h11 + DATA_W'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hB0 + DATA_W'(i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] simultaneous read and write while empty");
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] reset in the middle of a write burst");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h60 + DATA_W'(i), 1'b0, 1'b0);
    rx_irq = 1'b1;
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clock);
    idleInputs();
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] err_clear colliding with a new overflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

`ifdef FIFO_WATERMARK_EN
    $display("[TB] peak level tracking");
    idleInputs();
    reset = 1'b0;
    modelReset();
    #2;
    checkAll();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("peak_after_drain", 32'(peak_level), 32'd7);
    peak_clear = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    peak_clear = 1'b0;
    checkOutput("peak_after_clear", 32'(peak_level), 32'd2);
`endif

    idleInputs();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
